v30mz_prefetch_unit: RTL and testbench
======================================

Name: v30mz_prefetch_unit

Overview:
Parametrised bus control unit and instruction prefetch queue for the V30MZ core.
- Fetches code from {PS,0}+PFP over the external bus into a byte ring buffer.
- Exposes a multi-byte peek window and accepts variable-count pops, so the decoder can consume opcode, modrm, displacement and immediate bytes in a single cycle.
- Handles queue flush and redirect on branches, including single-byte fetches from odd addresses.
- Sits between the external bus pins and the decode/execute unit.

Parameters:
- DEPTH, 8: queue capacity in bytes; power of two, ≥ 2*BUS_BYTES.
- BUS_BYTES, 2: data bus width in bytes (1 or 2).
- PEEK_BYTES, 4: bytes visible on peek_data; ≤ DEPTH.
- CNT_W, 4: width of level and pop_count; must satisfy 2^CNT_W > DEPTH.

Ports:
- clk, in, 1: clock.
- reset, in, 1: synchronous, active-high.
- bus_data, in, 8*BUS_BYTES: read data; byte 0 is at the even address.
- bus_readyb, in, 1: active-low transfer-complete strobe.
- bus_addr, out, 20: fetch address.
- bus_status, out, 4: 4'hF idle, 4'h9 code read.
- flush, in, 1: discard the queue and redirect the fetch.
- flush_ps, in, 16: new PS, sampled when flush=1.
- flush_pc, in, 16: new PFP, sampled when flush=1.
- pop_count, in, CNT_W: number of bytes consumed this cycle.
- peek_data, out, 8*PEEK_BYTES: queue head; byte 0 is the oldest.
- level, out, CNT_W: valid bytes currently in the queue.
- full, out, 1: level == DEPTH.
- empty, out, 1: level == 0.

Behaviour:
Reset and address generation:
- Reset: PS=16'hFFFF, PFP=0, level=0, bus_status=4'hF, no fetch in flight. First fetch address is 20'hFFFF0.
- bus_addr = ({PS,4'b0} + {4'b0,PFP}) mod 2^20. PFP wraps at 16 bits inside the segment.

Fetch state machine (IDLE, REQ, DROP):
- Fetch size: n = 1 if BUS_BYTES == 2 and PFP[0] == 1, else BUS_BYTES.
- IDLE→REQ when free space (DEPTH − level + effective pop this cycle) ≥ n and flush=0. bus_status becomes 4'h9 in the same registered update.
- REQ, bus_readyb=0: bytes are taken from bus_data. An odd address takes the high byte only. The bytes are pushed, PFP += n, and the state returns to IDLE with status 4'hF. This gives at least one idle cycle between fetches.
- REQ, bus_readyb=1: bus_addr and status are held.
- flush while in REQ: the bus cycle cannot be aborted, so the state goes to DROP. DROP holds status 4'h9 and waits for readyb=0, discards the data, then goes to IDLE. The new PS/PFP are used for the next fetch.

Queue:
- Ring buffer with rd/wr pointers of log2(DEPTH) bits, wrapping modulo DEPTH.
- A push and a pop in the same cycle are both applied: level_next = level + pushed − popped.
- Effective pop = min(pop_count, level). Excess is ignored; the simulation-only assertion fires if pop_count > level.
- peek_data bytes at index ≥ level are don't-care; the bench must not check them.
- Pops compute from the current-cycle level only. A byte pushed this cycle is poppable next cycle.
- flush: level=0 and pointers cleared next cycle. pop_count is ignored in the flush cycle. Flush has priority over push, and an in-flight push is discarded.

Reset mid-fetch:
- Returns immediately to IDLE and the reset values. The bus side is assumed reset too.

Optional Feature:
V30MZ_PREFETCH_STATS_EN
- Defined: adds outputs stat_fetch_bytes[31:0] (bytes pushed), stat_starve_cycles[31:0] (cycles with empty=1 and pop_count≠0), and stat_flushes[15:0].
- All three counters saturate at maximum and are cleared by reset.
- Not defined: ports and logic are absent, and behaviour is otherwise identical.

Decomposition:
- Package v30mz_pkg holds:
  - bus status localparams BUS_IDLE=4'hF and BUS_CODE_READ=4'h9;
  - the fetch-state enum {IDLE, REQ, DROP};
  - the reset constants RESET_PS=16'hFFFF and RESET_PC=16'h0000.
- One sub-module, v30mz_byte_fifo:
  - parametrised DEPTH, PUSH_MAX=BUS_BYTES, PEEK=PEEK_BYTES;
  - variable push count and pop count, synchronous clear.
- The top level holds the fetch FSM, address generation and flush handling.

Test Plan:
1. Reset release, readyb=0 whenever status is 4'h9, pop_count=0 → addresses FFFF0, FFFF2, FFFF4, FFFF6. Level rises 2, 4, 6, 8, then full=1 and status stays 4'hF.
2. Queue full with bytes 00..07, pop_count=3 → next cycle level=5 and peek_data byte0=03. Fetch resumes at FFFF8.
3. flush with PS=1000, PC=0005 while idle → level=0. The next fetch is addr 10005 with a 1-byte push of the high byte; the following fetch is 10006, 2 bytes.
4. flush while REQ with readyb held high 3 cycles → status holds 4'h9. Data arriving on readyb=0 is dropped (level stays 0), then a fetch at the new address.
5. level=2, pop_count=2 in the same cycle as a 2-byte push completes → level=2 and peek byte0 is the first new byte.
6. PS=0000, PFP=FFFE → fetch FFFE, then PFP wraps to 0000 and the address is 00000. pop_count=5 with level=3 → level=0 and the assertion fires.

Source files
------------

// File: rtl/v30mz_pkg.sv
// Shared constants, fetch-state encoding and address helper for the V30MZ
// prefetch unit.
package v30mz_pkg;

  localparam logic [3:0]  BUS_IDLE      = 4'hF;
  localparam logic [3:0]  BUS_CODE_READ = 4'h9;
  localparam logic [15:0] RESET_PS      = 16'hFFFF;
  localparam logic [15:0] RESET_PC      = 16'h0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  // Segment:offset to 20-bit physical address; the carry out of bit 19 is dropped.
  function automatic logic [19:0] phys_addr(input logic [15:0] ps, input logic [15:0] pc);
    return {ps, 4'b0000} + {4'b0000, pc};
  endfunction

endpackage

// File: rtl/v30mz_prefetch_unit_if.sv
// External code-fetch bus between the prefetch unit (master) and the bus
// interface / memory (slave).
interface v30mz_prefetch_unit_if #(
  parameter int BUS_BYTES = 2
);
  logic [8*BUS_BYTES-1:0] bus_data;
  logic                   bus_readyb;
  logic [19:0]            bus_addr;
  logic [3:0]             bus_status;

  modport master (input bus_data, bus_readyb, output bus_addr, bus_status);
  modport slave  (output bus_data, bus_readyb, input bus_addr, bus_status);
endinterface

// File: rtl/v30mz_byte_fifo.sv
// Byte ring buffer with variable push/pop counts per cycle, a multi-byte
// peek window at the head and a synchronous clear.
module v30mz_byte_fifo #(
  parameter int DEPTH    = 8,
  parameter int PUSH_MAX = 2,
  parameter int PEEK     = 4,
  parameter int CNT_W    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_clear,
  input  logic [CNT_W-1:0]      i_push_cnt,
  input  logic [8*PUSH_MAX-1:0] i_push_data,
  input  logic [CNT_W-1:0]      i_pop_cnt,
  output logic [8*PEEK-1:0]     o_peek,
  output logic [CNT_W-1:0]      o_level
);
  localparam int PW = $clog2(DEPTH);

  logic [7:0]       r_mem [DEPTH];
  logic [PW-1:0]    r_rd;
  logic [PW-1:0]    r_wr;
  logic [CNT_W-1:0] r_level;
  logic [CNT_W-1:0] w_pop;

  // Never remove more bytes than are actually held.
  always_comb begin
    if (i_pop_cnt > r_level) begin
      w_pop = r_level;
    end else begin
      w_pop = i_pop_cnt;
    end
  end

  // Pointer and level bookkeeping; clear beats any push or pop in the same cycle.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_rd    <= {PW{1'b0}};
      r_wr    <= {PW{1'b0}};
      r_level <= {CNT_W{1'b0}};
    end else begin
      r_rd    <= r_rd + w_pop[PW-1:0];
      r_wr    <= r_wr + i_push_cnt[PW-1:0];
      r_level <= r_level + i_push_cnt - w_pop;
    end
  end

  // Byte storage: write only the lanes being pushed, starting at the write pointer.
  always_ff @(posedge clk) begin
    for (int i = 0; i < PUSH_MAX; i++) begin
      if (!reset && !i_clear && (i < int'(i_push_cnt))) begin
        r_mem[r_wr + PW'(i)] <= i_push_data[8*i +: 8];
      end
    end
  end

  // Peek window: byte 0 is the oldest byte in the queue.
  always_comb begin
    o_peek = {(8*PEEK){1'b0}};
    for (int i = 0; i < PEEK; i++) begin
      o_peek[8*i +: 8] = r_mem[r_rd + PW'(i)];
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/v30mz_prefetch_unit_chk.sv
// Simulation-side checker: flags a consumer popping more bytes than queued.
module v30mz_prefetch_unit_chk #(
  parameter int CNT_W = 4
) (
  input logic             clk,
  input logic             reset,
  input logic             i_flush,
  input logic [CNT_W-1:0] i_pop_count,
  input logic [CNT_W-1:0] i_level
);
  // Pops are ignored in a flush cycle, so only non-flush cycles are checked.
  property p_pop_within_level;
    @(posedge clk) disable iff (reset) (!i_flush) |-> (i_pop_count <= i_level);
  endproperty

  a_pop_within_level: assert property (p_pop_within_level)
    else $warning("pop_count %0d exceeds level %0d", i_pop_count, i_level);

endmodule

// File: rtl/v30mz_prefetch_unit.sv
// V30MZ bus control / instruction prefetch queue: fetches code from
// {PS,0}+PFP into a byte FIFO and exposes a peek window to the decoder.
// Optional statistics counters are enabled with `define V30MZ_PREFETCH_STATS_EN.
module v30mz_prefetch_unit
  import v30mz_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int BUS_BYTES  = 2,
  parameter int PEEK_BYTES = 4,
  parameter int CNT_W      = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  v30mz_prefetch_unit_if.master   bus,
  input  logic                    i_flush,
  input  logic [15:0]             i_flush_ps,
  input  logic [15:0]             i_flush_pc,
  input  logic [CNT_W-1:0]        i_pop_count,
  output logic [8*PEEK_BYTES-1:0] o_peek_data,
  output logic [CNT_W-1:0]        o_level,
  output logic                    o_full,
  output logic                    o_empty
`ifdef V30MZ_PREFETCH_STATS_EN
  ,
  output logic [31:0]             o_stat_fetch_bytes,
  output logic [31:0]             o_stat_starve_cycles,
  output logic [15:0]             o_stat_flushes
`endif
);
  fetch_state_e r_state;
  fetch_state_e w_state_nx;
  logic [15:0]  r_ps;
  logic [15:0]  r_pfp;
  logic [19:0]  r_addr;
  logic [3:0]   r_status;
  logic [3:0]   w_status_nx;
  logic         w_advance;
  logic         w_odd;
  logic [CNT_W-1:0] w_level;
  logic [CNT_W-1:0] w_pop_eff;
  logic [CNT_W-1:0] w_fetch_n;
  logic [CNT_W-1:0] w_free;
  logic [CNT_W-1:0] w_push_cnt;
  logic [8*BUS_BYTES-1:0] w_push_data;

  // A 16-bit bus at an odd PFP can only deliver the high byte.
  assign w_odd       = (BUS_BYTES == 2) && r_pfp[0];
  assign w_fetch_n   = w_odd ? CNT_W'(1) : CNT_W'(BUS_BYTES);
  assign w_push_data = w_odd ? (bus.bus_data >> 4'd8) : bus.bus_data;
  // Pops are ignored while flushing and clamped to the current level.
  assign w_pop_eff   = i_flush ? {CNT_W{1'b0}} :
                       ((i_pop_count > w_level) ? w_level : i_pop_count);
  assign w_free      = CNT_W'(DEPTH) - w_level + w_pop_eff;

  // Fetch FSM next-state and push decision.
  always_comb begin
    w_state_nx  = r_state;
    w_status_nx = r_status;
    w_push_cnt  = {CNT_W{1'b0}};
    w_advance   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!i_flush && (w_free >= w_fetch_n)) begin
          w_state_nx  = REQ;
          w_status_nx = BUS_CODE_READ;
        end else begin
          w_status_nx = BUS_IDLE;
        end
      end
      REQ: begin
        if (!bus.bus_readyb) begin
          w_state_nx  = IDLE;
          w_status_nx = BUS_IDLE;
          // Data completing in the flush cycle belongs to the old stream.
          if (!i_flush) begin
            w_push_cnt = w_fetch_n;
            w_advance  = 1'b1;
          end else begin
            w_push_cnt = {CNT_W{1'b0}};
          end
        end else if (i_flush) begin
          // The bus cycle cannot be aborted; wait it out and discard.
          w_state_nx = DROP;
        end else begin
          w_state_nx = REQ;
        end
      end
      DROP: begin
        if (!bus.bus_readyb) begin
          w_state_nx  = IDLE;
          w_status_nx = BUS_IDLE;
        end else begin
          w_state_nx = DROP;
        end
      end
      default: begin
        w_state_nx  = IDLE;
        w_status_nx = BUS_IDLE;
      end
    endcase
  end

  // State, fetch pointer and latched bus address.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_status <= BUS_IDLE;
      r_ps     <= RESET_PS;
      r_pfp    <= RESET_PC;
      r_addr   <= phys_addr(RESET_PS, RESET_PC);
    end else begin
      r_state  <= w_state_nx;
      r_status <= w_status_nx;
      if (i_flush) begin
        r_ps  <= i_flush_ps;
        r_pfp <= i_flush_pc;
      end else if (w_advance) begin
        r_pfp <= r_pfp + 16'(w_fetch_n);
      end else begin
        r_pfp <= r_pfp;
      end
      if ((r_state == IDLE) && (w_state_nx == REQ)) begin
        r_addr <= phys_addr(r_ps, r_pfp);
      end else begin
        r_addr <= r_addr;
      end
    end
  end

  assign bus.bus_addr   = r_addr;
  assign bus.bus_status = r_status;

  v30mz_byte_fifo #(
    .DEPTH(DEPTH), .PUSH_MAX(BUS_BYTES), .PEEK(PEEK_BYTES), .CNT_W(CNT_W)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (i_flush),
    .i_push_cnt  (w_push_cnt),
    .i_push_data (w_push_data),
    .i_pop_cnt   (w_pop_eff),
    .o_peek      (o_peek_data),
    .o_level     (w_level)
  );

  assign o_level = w_level;
  assign o_full  = (w_level == CNT_W'(DEPTH));
  assign o_empty = (w_level == {CNT_W{1'b0}});

  v30mz_prefetch_unit_chk #(.CNT_W(CNT_W)) u_chk (
    .clk         (clk),
    .reset       (reset),
    .i_flush     (i_flush),
    .i_pop_count (i_pop_count),
    .i_level     (w_level)
  );

`ifdef V30MZ_PREFETCH_STATS_EN
  logic [31:0] r_stat_bytes;
  logic [31:0] r_stat_starve;
  logic [15:0] r_stat_flush;

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_bytes  <= 32'd0;
      r_stat_starve <= 32'd0;
      r_stat_flush  <= 16'd0;
    end else begin
      if (r_stat_bytes > (32'hFFFF_FFFF - 32'(w_push_cnt))) begin
        r_stat_bytes <= 32'hFFFF_FFFF;
      end else begin
        r_stat_bytes <= r_stat_bytes + 32'(w_push_cnt);
      end
      if (o_empty && (i_pop_count != {CNT_W{1'b0}}) && (r_stat_starve != 32'hFFFF_FFFF)) begin
        r_stat_starve <= r_stat_starve + 32'd1;
      end else begin
        r_stat_starve <= r_stat_starve;
      end
      if (i_flush && (r_stat_flush != 16'hFFFF)) begin
        r_stat_flush <= r_stat_flush + 16'd1;
      end else begin
        r_stat_flush <= r_stat_flush;
      end
    end
  end

  assign o_stat_fetch_bytes   = r_stat_bytes;
  assign o_stat_starve_cycles = r_stat_starve;
  assign o_stat_flushes       = r_stat_flush;
`endif

endmodule

// File: tb/tb_v30mz_prefetch_unit.sv
// Bench for v30mz_prefetch_unit: a byte-queue scoreboard plus segment:offset
// address model, driven by directed scenarios and a randomized phase.
module tb_v30mz_prefetch_unit;
  localparam int DEPTH = 8, BUS_BYTES = 2, PEEK = 4, CNT_W = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic [15:0]       flush_ps, flush_pc;
  logic [CNT_W-1:0]  pop_count;
  logic [8*PEEK-1:0] peek_data;
  logic [CNT_W-1:0]  level;
  logic              full, empty;
`ifdef V30MZ_PREFETCH_STATS_EN
  logic [31:0] stat_fetch_bytes, stat_starve_cycles;
  logic [15:0] stat_flushes;
`endif

  v30mz_prefetch_unit_if #(.BUS_BYTES(BUS_BYTES)) bus_if ();

  v30mz_prefetch_unit #(
    .DEPTH(DEPTH), .BUS_BYTES(BUS_BYTES), .PEEK_BYTES(PEEK), .CNT_W(CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus_if.master),
    .i_flush     (flush),
    .i_flush_ps  (flush_ps),
    .i_flush_pc  (flush_pc),
    .i_pop_count (pop_count),
    .o_peek_data (peek_data),
    .o_level     (level),
    .o_full      (full),
    .o_empty     (empty)
`ifdef V30MZ_PREFETCH_STATS_EN
    ,
    .o_stat_fetch_bytes   (stat_fetch_bytes),
    .o_stat_starve_cycles (stat_starve_cycles),
    .o_stat_flushes       (stat_flushes)
`endif
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0]  q[$];
  logic [19:0] starts[$];
  logic [15:0] m_ps, m_pfp;
  bit          taint;
  logic [3:0]  prev_status;
  int          ready_mode;   // 0: ready at once, 1: random, 2: held off
  bit          rand_data;
  int          total = 0, bad = 0;

  function automatic logic [7:0] mem_byte(input logic [19:0] a);
    return a[7:0] + 8'h10;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: drive bus side, advance the model with this cycle's inputs, compare after the edge.
  task automatic step();
    logic [3:0]  st;
    logic [19:0] a, ea;
    logic [15:0] d;
    logic        rb;
    bit          done;
    int          pe;
    st = bus_if.bus_status;
    a  = bus_if.bus_addr;
    case (ready_mode)
      0:       rb = 1'b0;
      1:       rb = 1'($urandom_range(0, 1));
      default: rb = 1'b1;
    endcase
    d = {mem_byte(a | 20'h1), mem_byte(a & ~20'h1)};
    if (rand_data) d = d ^ 16'($urandom);
    bus_if.bus_data   = d;
    bus_if.bus_readyb = rb;
    done = 1'b0;
    if (reset) begin
      q.delete();
      m_ps = 16'hFFFF; m_pfp = 16'h0000; taint = 1'b0;
      prev_status = 4'hF;
    end else begin
      if (st == 4'h9 && prev_status != 4'h9) begin
        starts.push_back(a);
        ea = {m_ps, 4'h0} + {4'h0, m_pfp};
        chk("start_addr", 32'(a), 32'(ea));
      end
      done = (st == 4'h9) && !rb;
      if (flush) begin
        q.delete();
        m_ps = flush_ps; m_pfp = flush_pc;
        taint = (st == 4'h9) && !done;
      end else begin
        pe = (int'(pop_count) < q.size()) ? int'(pop_count) : q.size();
        repeat (pe) void'(q.pop_front());
        if (done && !taint) begin
          if (m_pfp[0]) begin
            q.push_back(d[15:8]);
            m_pfp = m_pfp + 16'd1;
          end else begin
            q.push_back(d[7:0]);
            q.push_back(d[15:8]);
            m_pfp = m_pfp + 16'd2;
          end
        end
        if (done) taint = 1'b0;
      end
      prev_status = st;
    end
    @(posedge clk);
    #1;
    chk("level", 32'(level), 32'(q.size()));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    for (int i = 0; i < PEEK; i++)
      if (i < q.size()) chk("peek", 32'(peek_data[8*i +: 8]), 32'(q[i]));
    if (done || reset) chk("status_idle", 32'(bus_if.bus_status), 32'hF);
    chk("status_legal", 32'(bus_if.bus_status == 4'hF || bus_if.bus_status == 4'h9), 32'd1);
  endtask

  task automatic do_flush(input logic [15:0] ps, input logic [15:0] pc);
    flush = 1'b1; flush_ps = ps; flush_pc = pc;
    step();
    flush = 1'b0;
  endtask

  initial begin
    int k, r, p;
    reset = 1'b1; flush = 1'b0; flush_ps = 16'h0; flush_pc = 16'h0; pop_count = '0;
    ready_mode = 0; rand_data = 1'b0; prev_status = 4'hF; taint = 1'b0;
    m_ps = 16'hFFFF; m_pfp = 16'h0;
    bus_if.bus_data = 16'h0; bus_if.bus_readyb = 1'b1;
    step(); step();
    chk("rst_addr", 32'(bus_if.bus_addr), 32'hFFFF0);
    chk("rst_status", 32'(bus_if.bus_status), 32'hF);
    chk("rst_level", 32'(level), 32'd0);
    reset = 1'b0;

    // 1: fill from reset vector
    starts.delete();
    repeat (16) step();
    chk("t1_a0", 32'(starts[0]), 32'hFFFF0);
    chk("t1_a1", 32'(starts[1]), 32'hFFFF2);
    chk("t1_a2", 32'(starts[2]), 32'hFFFF4);
    chk("t1_a3", 32'(starts[3]), 32'hFFFF6);
    chk("t1_level", 32'(level), 32'd8);
    chk("t1_full", 32'(full), 32'd1);
    chk("t1_status", 32'(bus_if.bus_status), 32'hF);

    // 2: pop three, fetch resumes at FFFF8
    starts.delete();
    pop_count = 4'd3; step(); pop_count = '0;
    chk("t2_level", 32'(level), 32'd5);
    chk("t2_peek0", 32'(peek_data[7:0]), 32'h03);
    repeat (4) step();
    chk("t2_addr", 32'(starts[0]), 32'hFFFF8);

    // 3: flush while idle to an odd offset
    k = 0;
    while (bus_if.bus_status != 4'hF && k < 20) begin step(); k++; end
    chk("t3_idle_wait", 32'(k < 20), 32'd1);
    starts.delete();
    do_flush(16'h1000, 16'h0005);
    chk("t3_level", 32'(level), 32'd0);
    repeat (6) step();
    chk("t3_a0", 32'(starts[0]), 32'h10005);
    chk("t3_a1", 32'(starts[1]), 32'h10006);

    // 4: flush during a stalled bus cycle
    ready_mode = 2;
    k = 0;
    while (bus_if.bus_status != 4'h9 && k < 20) begin step(); k++; end
    chk("t4_req_wait", 32'(k < 20), 32'd1);
    do_flush(16'h2000, 16'h0010);
    chk("t4_hold0", 32'(bus_if.bus_status), 32'h9);
    step(); chk("t4_hold1", 32'(bus_if.bus_status), 32'h9);
    step(); chk("t4_hold2", 32'(bus_if.bus_status), 32'h9);
    ready_mode = 0;
    starts.delete();
    step();
    chk("t4_dropped", 32'(level), 32'd0);
    repeat (4) step();
    chk("t4_addr", 32'(starts[0]), 32'h20010);

    // 5: pop two while a two-byte push completes
    do_flush(16'h3000, 16'h0000);
    k = 0;
    while (q.size() != 2 && k < 20) begin step(); k++; end
    ready_mode = 2;
    k = 0;
    while (bus_if.bus_status != 4'h9 && k < 20) begin step(); k++; end
    chk("t5_req_wait", 32'(k < 20), 32'd1);
    ready_mode = 0; pop_count = 4'd2; step(); pop_count = '0;
    chk("t5_level", 32'(level), 32'd2);
    chk("t5_peek0", 32'(peek_data[7:0]), 32'h12);

    // 6: offset wrap inside segment 0, then an over-pop
    starts.delete();
    do_flush(16'h0000, 16'hFFFE);
    k = 0;
    while (q.size() < 4 && k < 20) begin step(); k++; end
    ready_mode = 2;
    step();
    chk("t6_a0", 32'(starts[0]), 32'h0FFFE);
    chk("t6_a1", 32'(starts[1]), 32'h00000);
    pop_count = 4'd1; step();
    chk("t6_level3", 32'(level), 32'd3);
    pop_count = 4'd5; step(); pop_count = '0;
    chk("t6_level0", 32'(level), 32'd0);
    ready_mode = 0;

    // Randomized phase
    rand_data = 1'b1; ready_mode = 1;
    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      flush = ($urandom_range(0, 24) == 0);
      flush_ps = 16'($urandom); flush_pc = 16'($urandom);
      r = $urandom_range(0, 99);
      if (r < 2) p = q.size() + 1 + $urandom_range(0, 2);
      else       p = $urandom_range(0, q.size());
      if (p > 15) p = 15;
      pop_count = CNT_W'(p);
      step();
    end
    reset = 1'b0; flush = 1'b0; pop_count = '0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
